// File: rtl/ascon_pkg.sv
// Shared constants and FSM state type for the ascon output collector.
package ascon_pkg;

   localparam int unsigned K = 128;
   localparam int unsigned Y = 104;
   localparam int unsigned L = 40;
   localparam int unsigned T = 128;
   localparam int unsigned NBITS = (K > Y) ? ((K > L) ? K : L) : ((Y > L) ? Y : L);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCapture,
      StDone
   } state_e;

endpackage

// File: rtl/ascon_output_collector.sv
// Detects the ascon core's ready edge, waits SKIP cycles, then deserialises data and tag
// LSB-first into parallel words presented on a valid/ready interface.
module ascon_output_collector #(
   parameter int unsigned Y     = ascon_pkg::Y,
   parameter int unsigned T     = ascon_pkg::T,
   parameter int unsigned NBITS = ascon_pkg::NBITS,
   parameter int unsigned SKIP  = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ascon_readyxSO,
   input  logic         output_dataxSO,
   input  logic         tagxSO,
   input  logic         decrypt,
   input  logic [T-1:0] expected_tag,
   output logic [Y-1:0] out_data,
   output logic [T-1:0] out_tag,
   output logic         out_decrypt,
   output logic         tag_match,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         overrun
);
   import ascon_pkg::*;

   localparam int unsigned IW = $clog2(NBITS);
   localparam int unsigned CW = (SKIP > 1) ? $clog2(SKIP) : 1;

   state_e         state_q, state_d;
   logic           ready_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [Y-1:0]   data_q, data_d;
   logic [T-1:0]   tag_q, tag_d;
   logic           dec_q, dec_d;
   logic           match_q, match_d;
   logic           overrun_q, overrun_d;
   logic           rise;

   assign rise = ascon_readyxSO & ~ready_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      tag_d     = tag_q;
      dec_d     = dec_q;
      match_d   = match_q;
      overrun_d = rise & (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (rise) begin
               dec_d   = decrypt;
               data_d  = '0;
               tag_d   = '0;
               match_d = 1'b0;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = (SKIP > 0) ? StWait : StCapture;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (32'(cnt_q) == SKIP - 1) begin
               state_d = StCapture;
               idx_d   = '0;
            end
         end
         StCapture: begin
            if (32'(idx_q) < Y) data_d[idx_q] = output_dataxSO;
            if (32'(idx_q) < T) tag_d[idx_q] = tagxSO;
            idx_d = idx_q + 1'b1;
            // Compare against the tag including the bit captured on this edge.
            if (32'(idx_q) == NBITS - 1) begin
               state_d = StDone;
               match_d = (tag_d == expected_tag);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ready_q   <= 1'b1;
         cnt_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         tag_q     <= '0;
         dec_q     <= 1'b0;
         match_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ascon_readyxSO;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         tag_q     <= tag_d;
         dec_q     <= dec_d;
         match_q   <= match_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_data    = data_q;
   assign out_tag     = tag_q;
   assign out_decrypt = dec_q;
   assign tag_match   = match_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != StIdle);
   assign out_valid   = (state_q == StDone);

endmodule

// File: tb/tb_ascon_output_collector.sv
// Directed bench for ascon_output_collector: a SKIP=2 instance and a SKIP=0 instance share the
// serial lines; each has its own ready input so only the selected one captures.
module tb_ascon_output_collector;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy0, rdy1;
   logic         sdata, stag;
   logic         decrypt;
   logic [127:0] etag;
   logic         out_ready;

   logic [103:0] od0, od1;
   logic [127:0] ot0, ot1;
   logic         odec0, odec1, match0, match1, valid0, valid1, busy0, busy1, ovr0, ovr1;

   logic         sel;
   logic [103:0] od;
   logic [127:0] ot;
   logic         odec, match, valid, busy;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [103:0] EncData = 104'h18490112f8d5867a830748390b;
   localparam logic [127:0] EncTag  = 128'hA5A5_0F0F_3C3C_FFFF_0000_1234_5678_9ABC;
   localparam logic [103:0] DecData = 104'h6173636f6e2d756e6963617373;
   localparam logic [127:0] DecTag  = 128'hDEADBEEF_00000000_CAFEF00D_12345678;

   always #5 clk = ~clk;

   ascon_output_collector #(.SKIP(2)) dut0 (
      .clk(clk), .rst(rst), .ascon_readyxSO(rdy0), .output_dataxSO(sdata), .tagxSO(stag),
      .decrypt(decrypt), .expected_tag(etag), .out_data(od0), .out_tag(ot0),
      .out_decrypt(odec0), .tag_match(match0), .out_valid(valid0), .out_ready(out_ready),
      .busy(busy0), .overrun(ovr0)
   );

   ascon_output_collector #(.SKIP(0)) dut1 (
      .clk(clk), .rst(rst), .ascon_readyxSO(rdy1), .output_dataxSO(sdata), .tagxSO(stag),
      .decrypt(decrypt), .expected_tag(etag), .out_data(od1), .out_tag(ot1),
      .out_decrypt(odec1), .tag_match(match1), .out_valid(valid1), .out_ready(out_ready),
      .busy(busy1), .overrun(ovr1)
   );

   assign od    = sel ? od1 : od0;
   assign ot    = sel ? ot1 : ot0;
   assign odec  = sel ? odec1 : odec0;
   assign match = sel ? match1 : match0;
   assign valid = sel ? valid1 : valid0;
   assign busy  = sel ? busy1 : busy0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_rdy(input logic v);
      if (sel) rdy1 = v;
      else rdy0 = v;
   endtask

   // Lower then raise ready; the posedge after the raise is detection edge 0. Bit i is driven
   // before edge skip+1+i. Returns the first edge k at which out_valid is seen high just
   // before k (skip+129), or -1. abort_e > 0 stops early, just before that edge.
   task automatic run_capture(input int skip, input logic [103:0] d, input logic [127:0] tg,
                              input logic dec, input logic [127:0] et, input int abort_e,
                              output int valid_edge);
      int bi;
      decrypt    = dec;
      etag       = et;
      valid_edge = -1;
      @(negedge clk) set_rdy(1'b0);
      @(negedge clk);
      @(negedge clk) set_rdy(1'b1);
      for (int e = 1; e <= 300 && valid_edge < 0; e++) begin
         @(negedge clk);
         if (abort_e > 0 && e == abort_e) return;
         if (valid) valid_edge = e;
         bi    = e - skip - 1;
         sdata = (bi >= 0 && bi < 104) ? d[bi] : 1'b0;
         stag  = (bi >= 0 && bi < 128) ? tg[bi] : 1'b0;
      end
   endtask

   task automatic accept();
      @(negedge clk) out_ready = 1'b1;
      @(negedge clk) out_ready = 1'b0;
      check("acc_valid", 128'(valid), 128'd0);
      check("acc_busy", 128'(busy), 128'd0);
   endtask

   initial begin
      int ve, ovr_cnt;
      logic bad;
      logic [103:0] snap_d;
      logic [127:0] snap_t;
      rst = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; sdata = 1'b0; stag = 1'b0;
      decrypt = 1'b0; etag = '0; out_ready = 1'b0; sel = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_data", 128'(od0), 128'd0);
      check("rst_tag", ot0, 128'd0);
      check("rst_valid", 128'(valid0), 128'd0);
      check("rst_busy", 128'(busy0), 128'd0);
      check("rst_ovr", 128'(ovr0), 128'd0);
      check("rst_match", 128'(match0), 128'd0);

      // Encrypt capture
      run_capture(2, EncData, EncTag, 1'b0, 128'd0, 0, ve);
      check("enc_vedge", 128'(ve), 128'd131);
      check("enc_data", 128'(od), 128'(EncData));
      check("enc_tag", ot, EncTag);
      check("enc_dec", 128'(odec), 128'd0);
      check("enc_busy", 128'(busy), 128'd1);
      accept();

      // Decrypt, tag match
      run_capture(2, DecData, DecTag, 1'b1, DecTag, 0, ve);
      check("dm_data", 128'(od), 128'(DecData));
      check("dm_tag", ot, DecTag);
      check("dm_match", 128'(match), 128'd1);
      check("dm_dec", 128'(odec), 128'd1);
      accept();

      // Decrypt, tag mismatch in bit 127; then hold under backpressure
      run_capture(2, DecData, DecTag, 1'b1, DecTag ^ {1'b1, 127'd0}, 0, ve);
      check("mm_match", 128'(match), 128'd0);
      check("mm_tag", ot, DecTag);
      snap_d = od; snap_t = ot; bad = 1'b0; ovr_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (c == 10) rdy0 = 1'b0;
         if (c == 20) rdy0 = 1'b1;
         if (ovr0) ovr_cnt++;
         if (od !== snap_d || ot !== snap_t || valid !== 1'b1 || match !== 1'b0
             || odec !== 1'b1) bad = 1'b1;
      end
      check("bp_stable", 128'(bad), 128'd0);
      check("bp_ovr", 128'(ovr_cnt), 128'd1);
      accept();
      repeat (5) @(negedge clk);
      check("bp_idle", 128'(busy), 128'd0);

      // Ready rise on the same edge as the handshake: overrun, no new run
      run_capture(2, EncData, EncTag, 1'b0, 128'd0, 0, ve);
      @(negedge clk) rdy0 = 1'b0;
      @(negedge clk) begin rdy0 = 1'b1; out_ready = 1'b1; end
      @(negedge clk) out_ready = 1'b0;
      check("hs_ovr", 128'(ovr0), 128'd1);
      check("hs_busy", 128'(busy), 128'd0);
      repeat (3) @(negedge clk);
      check("hs_idle", 128'(busy), 128'd0);

      // Reset mid-capture at idx 60
      run_capture(2, EncData, EncTag, 1'b0, 128'd0, 63, ve);
      check("mid_busy", 128'(busy), 128'd1);
      rst = 1'b1;
      #1;
      check("mid_data", 128'(od0), 128'd0);
      check("mid_tag", ot0, 128'd0);
      check("mid_bsy0", 128'(busy0), 128'd0);
      @(negedge clk) rst = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_norun", 128'(busy0), 128'd0);
      run_capture(2, EncData, EncTag, 1'b0, 128'd0, 0, ve);
      check("mid_vedge", 128'(ve), 128'd131);
      check("mid_data2", 128'(od), 128'(EncData));
      accept();

      // SKIP=0 instance
      sel = 1'b1;
      run_capture(0, EncData, EncTag, 1'b0, 128'd0, 0, ve);
      check("s0_vedge", 128'(ve), 128'd129);
      check("s0_data", 128'(od), 128'(EncData));
      check("s0_tag", ot, EncTag);
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
